// File: rtl/mult_rr_scheduler.sv
// Round-robin front end for one shared multi-cycle signed multiplier: grants one requester
// at a time, launches the multiplier, waits with a watchdog and returns the tagged product.
module mult_rr_scheduler #(
  parameter int DATAWIDTH = 8,
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_b,
  output logic                           mul_en,
  output logic [DATAWIDTH-1:0]           mul_multiplier,
  output logic [DATAWIDTH-1:0]           mul_multiplicand,
  input  logic                           mul_done,
  input  logic [2*DATAWIDTH-1:0]         mul_product,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [2*DATAWIDTH-1:0]         rsp_product,
  output logic                           busy,
  output logic                           err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        last_q, last_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [DATAWIDTH-1:0]   a_q, a_d;
  logic [DATAWIDTH-1:0]   b_q, b_d;
  logic [2*DATAWIDTH-1:0] prod_q, prod_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   err_q, err_d;

  logic                   grant_found;
  logic [ID_W-1:0]        grant_idx;
  logic [ID_W-1:0]        cand;
  int unsigned            cand_u;

  // Search starts just after the previous winner so every client gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    cand_u      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand_u = (32'(last_q) + k) % NUM_REQ;
      cand   = cand_u[ID_W-1:0];
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    timer_d = timer_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          a_d     = req_a[grant_idx*DATAWIDTH +: DATAWIDTH];
          b_d     = req_b[grant_idx*DATAWIDTH +: DATAWIDTH];
          id_d    = grant_idx;
          last_d  = grant_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // Completion takes priority over a simultaneous watchdog expiry.
        if (mul_done) begin
          prod_d  = mul_product;
          state_d = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign mul_en           = (state_q == S_ISSUE);
  assign mul_multiplier   = a_q;
  assign mul_multiplicand = b_q;
  assign rsp_valid        = (state_q == S_RESP);
  assign rsp_id           = id_q;
  assign rsp_product      = prod_q;
  assign busy             = (state_q != S_IDLE);
  assign err_timeout      = err_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Scoreboard bench for mult_rr_scheduler with a behavioural multi-cycle multiplier model.
`timescale 1ns/1ps
module tb_mult_rr_scheduler;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_a = '0;
  logic [N*DW-1:0]   req_b = '0;
  logic              mul_en;
  logic [DW-1:0]     mul_multiplier;
  logic [DW-1:0]     mul_multiplicand;
  logic              mul_done = 1'b0;
  logic [2*DW-1:0]   mul_product = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IW-1:0]     rsp_id;
  logic [2*DW-1:0]   rsp_product;
  logic              busy;
  logic              err_timeout;

  mult_rr_scheduler #(
    .DATAWIDTH(DW),
    .NUM_REQ  (N),
    .ID_W     (IW),
    .TIMEOUT  (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_a           (req_a),
    .req_b           (req_b),
    .mul_en          (mul_en),
    .mul_multiplier  (mul_multiplier),
    .mul_multiplicand(mul_multiplicand),
    .mul_done        (mul_done),
    .mul_product     (mul_product),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_product     (rsp_product),
    .busy            (busy),
    .err_timeout     (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } op_t;

  typedef struct packed {
    logic [IW-1:0]   id;
    logic [2*DW-1:0] p;
  } exp_t;

  op_t  jq [N][$];
  exp_t exp_q[$];
  int   dut_grants[$];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  int          last_m    = N - 1;
  bit          inflight  = 1'b0;
  int          age       = 0;
  bit          no_done   = 1'b0;
  bit          stray_en  = 1'b0;
  int          fixed_lat = 0;
  int          rsp_mode  = 0;
  int          stall_cnt = 0;
  bit          post_rst  = 1'b0;
  int          n_err     = 0;
  logic [2*DW-1:0] last_rsp_p  = '0;
  logic [IW-1:0]   last_rsp_id = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  function automatic logic [2*DW-1:0] smul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [2*DW-1:0] r;
    r = $signed(a) * $signed(b);
    return r;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit all_idle();
    for (int i = 0; i < N; i++) if (jq[i].size() != 0) return 1'b0;
    return !inflight && exp_q.size() == 0;
  endfunction

  task automatic push_job(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b);
    op_t o;
    o.a = a;
    o.b = b;
    jq[r].push_back(o);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (jq[i].size() > 0) begin
        req_valid[i]        = 1'b1;
        req_a[i*DW +: DW]   = jq[i][0].a;
        req_b[i*DW +: DW]   = jq[i][0].b;
      end else begin
        req_valid[i]        = 1'b0;
        req_a[i*DW +: DW]   = DW'($urandom);
        req_b[i*DW +: DW]   = DW'($urandom);
      end
    end
    case (rsp_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = (stall_cnt >= 10);
    endcase
  endtask

  // One cycle of the reference model: sample at negedge, drive just after posedge.
  task automatic step();
    logic [N-1:0] exp_ready;
    int           g;
    bit           exp_err;
    exp_t         e;
    @(negedge clk);
    if (rst) begin
      inflight  = 1'b0;
      last_m    = N - 1;
      stall_cnt = 0;
      no_done   = 1'b0;
      exp_q.delete();
      post_rst  = 1'b1;
    end else begin
      if (post_rst) begin
        check("reset_outputs", {busy, rsp_valid, mul_en, err_timeout, rsp_id,
                                mul_multiplier, mul_multiplicand}, '0);
        check("reset_product", rsp_product, '0);
        post_rst = 1'b0;
      end
      if (inflight) age++;
      exp_err = inflight && no_done && (age == TO + 2);
      if (err_timeout || exp_err) check("err_timeout", err_timeout, exp_err);
      if (err_timeout) begin
        n_err++;
        inflight = 1'b0;
        no_done  = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      exp_ready = '0;
      g = -1;
      if (!inflight) begin
        g = rr_pick(req_valid, last_m);
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      check("req_ready", req_ready, exp_ready);
      check("busy", busy, inflight);
      check("mul_en", mul_en, inflight && age == 1);
      if (|(req_valid & req_ready)) dut_grants.push_back(idx_of(req_valid & req_ready));
      if (rsp_valid && !rsp_ready) stall_cnt++;
      if (rsp_valid && rsp_ready) begin
        inflight  = 1'b0;
        stall_cnt = 0;
      end
      if (g >= 0) begin
        last_m   = g;
        inflight = 1'b1;
        age      = 0;
        e.id     = IW'(g);
        e.p      = smul(jq[g][0].a, jq[g][0].b);
        exp_q.push_back(e);
        void'(jq[g].pop_front());
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_until_idle(input string name, input int max_cycles);
    int c;
    c = 0;
    while (!all_idle() && c < max_cycles) begin
      step();
      c++;
    end
    if (!all_idle()) begin
      n_checks++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, c);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  // Multiplier stand-in: product returned lat cycles after mul_en, plus optional stray strobes.
  initial begin
    bit            active;
    int            cnt;
    logic [DW-1:0] pa, pb;
    logic          nd;
    logic [2*DW-1:0] np;
    active = 1'b0;
    cnt    = 0;
    pa     = '0;
    pb     = '0;
    forever begin
      @(negedge clk);
      nd = 1'b0;
      np = 16'($urandom);
      if (rst) begin
        active = 1'b0;
      end else if (mul_en) begin
        active = !no_done;
        cnt    = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 20);
        pa     = mul_multiplier;
        pb     = mul_multiplicand;
      end else if (active) begin
        cnt--;
        if (cnt == 0) begin
          nd     = 1'b1;
          np     = smul(pa, pb);
          active = 1'b0;
        end
      end else if (stray_en && !no_done && $urandom_range(0, 7) == 0) begin
        nd = 1'b1;
      end
      @(posedge clk);
      #1;
      mul_done    = nd;
      mul_product = np;
    end
  end

  // Response monitor: pops the scoreboard on each handshake and checks hold-stability.
  initial begin
    bit              held;
    logic [IW-1:0]   hid;
    logic [2*DW-1:0] hp;
    exp_t            e;
    held = 1'b0;
    hid  = '0;
    hp   = '0;
    forever begin
      @(negedge clk);
      if (rst || !rsp_valid) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("rsp_id_stable", rsp_id, hid);
          check("rsp_product_stable", rsp_product, hp);
        end
        if (rsp_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL rsp_unexpected: actual id %0d product %0h, required no response",
                     rsp_id, rsp_product);
          end else begin
            e = exp_q.pop_front();
            check("rsp_id", rsp_id, e.id);
            check("rsp_product", rsp_product, e.p);
            last_rsp_p  = rsp_product;
            last_rsp_id = rsp_id;
          end
        end else begin
          held = 1'b1;
          hid  = rsp_id;
          hp   = rsp_product;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int c;
    drive();
    do_reset(2);

    // All four requesters held valid from reset: grants must rotate 0,1,2,3,0,1,2,3.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) push_job(i, DW'($urandom), DW'($urandom));
    dut_grants.delete();
    drive();
    run_until_idle("order_drain", 2000);
    check("grant_count", dut_grants.size(), 8);
    for (int k = 0; k < 8 && k < dut_grants.size(); k++)
      check("grant_order", dut_grants[k], k % N);

    push_job(0, 8'd3, 8'hFB);
    drive();
    run_until_idle("dir0_drain", 200);
    check("dir_3xm5_product", last_rsp_p, 16'hFFF1);
    check("dir_3xm5_id", last_rsp_id, 0);

    push_job(2, 8'h80, 8'h80);
    drive();
    run_until_idle("dir1_drain", 200);
    check("dir_m128sq_product", last_rsp_p, 16'h4000);
    check("dir_m128sq_id", last_rsp_id, 2);

    push_job(2, 8'h7F, 8'h7F);
    drive();
    run_until_idle("dir2_drain", 200);
    check("dir_127sq_product", last_rsp_p, 16'h3F01);

    rsp_mode = 2;
    push_job(1, DW'($urandom), DW'($urandom));
    push_job(3, DW'($urandom), DW'($urandom));
    drive();
    run_until_idle("stall_drain", 400);
    rsp_mode = 0;

    no_done = 1'b1;
    n_err   = 0;
    push_job(3, DW'($urandom), DW'($urandom));
    push_job(0, DW'($urandom), DW'($urandom));
    drive();
    run_until_idle("timeout_drain", 600);
    check("timeout_pulses", n_err, 1);

    fixed_lat = 30;
    push_job(1, DW'($urandom), DW'($urandom));
    drive();
    c = 0;
    while (!(inflight && age == 3) && c < 100) begin
      step();
      c++;
    end
    if (!(inflight && age == 3)) begin
      n_checks++;
      $display("FAIL midwait_reach: job not in flight after %0d cycles, required WAIT", c);
    end
    do_reset(1);
    fixed_lat = 0;
    step();
    push_job(3, DW'($urandom), DW'($urandom));
    push_job(1, DW'($urandom), DW'($urandom));
    dut_grants.delete();
    drive();
    run_until_idle("post_reset_drain", 400);
    check("post_reset_grants", dut_grants.size(), 2);
    if (dut_grants.size() > 0) check("post_reset_first", dut_grants[0], 1);

    rsp_mode = 1;
    stray_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      push_job($urandom_range(0, N - 1), DW'($urandom), DW'($urandom));
      repeat ($urandom_range(0, 8)) step();
    end
    run_until_idle("random_drain", 5000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
